// File: rtl/d_ff_pkg.sv
// d_ff_pkg: shared defaults for the d_flip_flop register family.
package d_ff_pkg;
    localparam int DFF_DEFAULT_WIDTH  = 1;
    localparam int DFF_DEFAULT_STAGES = 1;
endpackage

// File: rtl/d_ff_cell.sv
// d_ff_cell: one WIDTH-bit register stage, sync active-high reset on rst_n.
// Optional D_FF_ENABLE_EN adds a load enable that reset overrides.
module d_ff_cell
    import d_ff_pkg::*;
#(
    parameter int                 WIDTH       = DFF_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef D_FF_ENABLE_EN
    input  logic             en,
`endif
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] r_q;
    always_ff @(posedge clk) begin
        if (rst_n)
            r_q <= RESET_VALUE;
`ifdef D_FF_ENABLE_EN
        else if (en)
            r_q <= d;
`else
        else
            r_q <= d;
`endif
    end
    assign q = r_q;
endmodule

// File: rtl/d_flip_flop.sv
// d_flip_flop: STAGES-deep chain of d_ff_cell registers with complemented output.
// Optional D_FF_ENABLE_EN adds an `en` port that stalls the whole chain.
module d_flip_flop
    import d_ff_pkg::*;
#(
    parameter int               WIDTH       = DFF_DEFAULT_WIDTH,
    parameter int               STAGES      = DFF_DEFAULT_STAGES,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef D_FF_ENABLE_EN
    input  logic             en,
`endif
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n
);
    generate
        if (STAGES < 1 || WIDTH < 1) begin : g_bad_params
            $error("d_flip_flop: STAGES and WIDTH must both be >= 1");
        end
    endgenerate
    // w_chain[0] is the input, w_chain[STAGES] the last stage
    logic [WIDTH-1:0] w_chain [0:STAGES];
    assign w_chain[0] = d;
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        d_ff_cell #(
            .WIDTH      (WIDTH),
            .RESET_VALUE(RESET_VALUE)
        ) u_cell (
            .clk  (clk),
            .rst_n(rst_n),
`ifdef D_FF_ENABLE_EN
            .en   (en),
`endif
            .d    (w_chain[i]),
            .q    (w_chain[i+1])
        );
    end
    assign q   = w_chain[STAGES];
    assign q_n = ~q;
endmodule

// File: tb/tb_d_flip_flop.sv
// tb_d_flip_flop: randomized self-checking bench for a 1x1 DFF and an 8-bit 3-stage pipeline.
// Exercises the en port when D_FF_ENABLE_EN is defined.
module tb_d_flip_flop;
    typedef struct {
        logic       r;
        logic [7:0] d;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       d1;
    logic       q1;
    logic       qn1;
    logic [7:0] d8;
    logic [7:0] q8;
    logic [7:0] qn8;
    int         n_checks;
    int         n_errors;
    ev_t        h1[$];
    ev_t        h8[$];
    logic [7:0] e1;
    logic [7:0] e8;

    d_flip_flop #(.WIDTH(1), .STAGES(1), .RESET_VALUE(1'b0)) u_dff1 (
        .clk  (clk),
        .rst_n(rst_n),
`ifdef D_FF_ENABLE_EN
        .en   (en),
`endif
        .d    (d1),
        .q    (q1),
        .q_n  (qn1)
    );

    d_flip_flop #(.WIDTH(8), .STAGES(3), .RESET_VALUE(8'hA5)) u_dff8 (
        .clk  (clk),
        .rst_n(rst_n),
`ifdef D_FF_ENABLE_EN
        .en   (en),
`endif
        .d    (d8),
        .q    (q8),
        .q_n  (qn8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // q is the value sampled s effective edges ago, unless a reset landed within those s edges
    function automatic logic [7:0] model_q(input ev_t h[$], input int s, input logic [7:0] rv);
        if (h.size() < s) return rv;
        for (int i = 0; i < s; i++)
            if (h[h.size()-1-i].r) return rv;
        return h[h.size()-s].d;
    endfunction

    task automatic tick();
        @(posedge clk);
`ifdef D_FF_ENABLE_EN
        if (rst_n || en) begin
`else
        begin
`endif
            h1.push_back('{r: rst_n, d: {7'b0, d1}});
            h8.push_back('{r: rst_n, d: d8});
        end
        e1 = model_q(h1, 1, 8'h00);
        e8 = model_q(h8, 3, 8'hA5);
        #1;
        check("q1", {7'b0, q1}, e1);
        check("qn1", {7'b0, qn1}, {7'b0, ~e1[0]});
        check("q8", q8, e8);
        check("qn8", qn8, ~e8);
    endtask

    initial begin
        logic [6:0] seq;
        n_checks = 0;
        n_errors = 0;
        en    = 1'b1;
        rst_n = 1'b1;
        d1    = 1'b1;
        d8    = 8'($urandom);
        #2;
        repeat (2) tick();
        // pipeline reset value spot check independent of the model
        check("q8_rst", q8, 8'hA5);
        rst_n = 1'b0;
        seq   = 7'b1100101;
        for (int i = 0; i < 7; i++) begin
            d1 = seq[i];
            d8 = (i < 3) ? 8'(i + 1) : 8'($urandom);
            tick();
            check("seq_q1", {7'b0, q1}, {7'b0, seq[i]});
            if (i < 2) check("pipe_hold", q8, 8'hA5);
            if (i >= 2 && i < 5) check("pipe_out", q8, 8'(i - 1));
        end
        d1 = 1'b0;
        tick();
        #3 d1 = 1'b1;
        #2 d1 = 1'b0;
        tick();
        check("glitch", {7'b0, q1}, 8'h00);
        d1 = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_rst", {7'b0, q1}, 8'h00);
        rst_n = 1'b0;
        tick();
        check("post_rst", {7'b0, q1}, 8'h01);
`ifdef D_FF_ENABLE_EN
        d1 = 1'b1;
        en = 1'b1;
        tick();
        en = 1'b0;
        d1 = 1'b0;
        repeat (3) begin
            tick();
            check("en_hold", {7'b0, q1}, 8'h01);
        end
        en = 1'b1;
        tick();
        check("en_load", {7'b0, q1}, 8'h00);
        d1    = 1'b1;
        tick();
        rst_n = 1'b1;
        en    = 1'b0;
        tick();
        check("en_rst", {7'b0, q1}, 8'h00);
        rst_n = 1'b0;
`endif
        for (int i = 0; i < 60; i++) begin
            d1    = 1'($urandom);
            d8    = 8'($urandom);
            rst_n = ($urandom_range(0, 7) == 0);
            en    = ($urandom_range(0, 3) != 0);
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/d_flip_flop.md
Name: d_flip_flop

Overview:
- Parameterizable D-type register: captures `d` on each rising edge of `clk` and drives it on `q`.
- Optional N-stage pipeline depth for delay lines and synchronizers.
- Leaf storage primitive used throughout the datapath wherever a clocked, resettable bit or bus register is needed.
- Single clock domain; synchronous active-high reset.

Parameters:
- WIDTH, 1: bit width of `d` and `q`.
- STAGES, 1: number of cascaded register stages between `d` and `q` (≥1).
- RESET_VALUE, {WIDTH{1'b0}}: value loaded into every stage on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset. Port name kept as in the codebase, but the reset is synchronous and ACTIVE-HIGH: rst_n=1 resets.
- d  input  WIDTH  data in.
- q  output  WIDTH  registered data out (last stage).
- q_n  output  WIDTH  bitwise complement of q.

Behaviour:
- All state updates occur only on posedge clk. There is no asynchronous path from rst_n or d to q.
- At a rising edge with rst_n=1:
  - every stage loads RESET_VALUE;
  - after that edge, q=RESET_VALUE and q_n=~RESET_VALUE.
- At a rising edge with rst_n=0:
  - stage[0] <= d;
  - stage[i] <= stage[i-1] for i=1..STAGES-1;
  - q = stage[STAGES-1].
- Latency is STAGES clock edges from d to q. STAGES=1 gives a classic DFF: q after edge k equals d sampled at edge k.
- Reset has priority over data when both are present at the same edge.
- Reset asserted mid-stream flushes all stages in one edge. In-flight data is lost.
- After rst_n deasserts, q shows RESET_VALUE until the first post-reset data reaches the last stage, STAGES edges later.
- q_n is combinational from q (~q). It carries no extra register and no extra latency.
- Power-up state before the first edge is X in simulation. No initial blocks are used for synthesis.
- d changing between edges has no effect on q. Only the value at setup before the edge is captured.
- STAGES<1 or WIDTH<1 must fail elaboration via a generate-time error check.

Optional Feature:
- Macro: D_FF_ENABLE_EN.
- Defined:
  - adds input port `en` (1 bit), placed after rst_n;
  - at a rising edge with rst_n=0 and en=0, all stages hold their value (the whole pipeline stalls);
  - with en=1, behaviour is as above;
  - reset overrides en.
- Undefined:
  - no `en` port;
  - the register loads on every edge.

Decomposition:
- Shared package d_ff_pkg holds:
  - default constant DFF_DEFAULT_WIDTH = 1;
  - default constant DFF_DEFAULT_STAGES = 1.
- Natural sub-module: d_ff_cell, a single WIDTH-bit stage with clk, rst_n (sync, active-high), optional en, d and q.
- d_flip_flop instantiates STAGES d_ff_cell instances in a generate chain and derives q_n.

Test Plan:
- Reset: WIDTH=1, STAGES=1. Drive rst_n=1, d=1 over 2 edges -> q=0 and q_n=1 after the first edge; d is ignored.
- Data capture: release reset, then apply d sequence 1,0,1,0,0,1,1, one value per 10 ns clock period -> after each edge q equals the d of that edge: 1,0,1,0,0,1,1.
- Mid-cycle glitch: toggle d 0->1->0 between two edges -> q unchanged (0) at the next edge.
- Reset mid-operation: set q=1, then assert rst_n=1 for one edge with d=1 -> q=0 at that edge. Deassert -> q=1 at the next edge.
- Pipeline: STAGES=3, WIDTH=8, RESET_VALUE=8'hA5.
  - After reset, q=8'hA5 for 2 more edges.
  - Then drive d=8'h01, 8'h02, 8'h03 on consecutive edges -> q shows 8'h01, 8'h02, 8'h03 starting 3 edges after 8'h01 was sampled.
- With D_FF_ENABLE_EN: load q=1, then hold en=0 for 3 edges with d=0 -> q stays 1. Set en=1 -> q=0 at the next edge. Apply rst_n=1 with en=0 -> q=0.
